// File: rtl/pmem_arbiter_pkg.sv
// Shared types and helpers for the N-channel physical-memory arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    localparam int MAX_CH    = 8;

    // Encodes a one-hot vector by OR-ing the indices of its set bits.
    function automatic int onehot_to_idx(input logic [MAX_CH-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pmem_arbiter_rr_pick.sv
// Combinational winner selection: rotating priority from ptr, or lowest index when mode is set.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] valid,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              mode,
    output logic [IDX_W-1:0]  winner,
    output logic              any_valid
);

    logic [NUM_CH-1:0] oh_s;
    logic [IDX_W:0]    sum_s;
    logic [IDX_W-1:0]  j_s;

    // Scan channels in priority order and keep only the first valid one.
    always_comb begin
        oh_s  = '0;
        sum_s = '0;
        j_s   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mode) begin
                j_s = IDX_W'(k);
            end else begin
                sum_s = {1'b0, ptr} + (IDX_W + 1)'(k);
                if (sum_s >= (IDX_W + 1)'(NUM_CH)) begin
                    sum_s = sum_s - (IDX_W + 1)'(NUM_CH);
                end else begin
                    sum_s = sum_s;
                end
                j_s = sum_s[IDX_W-1:0];
            end
            if ((oh_s == '0) && valid[j_s]) begin
                oh_s[j_s] = 1'b1;
            end else begin
                oh_s = oh_s;
            end
        end
    end

    assign winner    = IDX_W'(onehot_to_idx(MAX_CH'(oh_s)));
    assign any_valid = |valid;

endmodule

// File: rtl/pmem_arbiter.sv
// N-channel cache-line arbiter in front of a single line-wide physical memory port.
module pmem_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int ARB_MODE   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_read,
    input  logic [NUM_CH-1:0]            ch_write,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_address,
    input  logic [NUM_CH*LINE_WIDTH-1:0] ch_wdata,
    output logic [NUM_CH-1:0]            ch_resp,
    output logic [LINE_WIDTH-1:0]        ch_rdata,
    output logic                         pmem_read,
    output logic                         pmem_write,
    output logic [ADDR_WIDTH-1:0]        pmem_address,
    output logic [LINE_WIDTH-1:0]        pmem_wdata,
    input  logic                         pmem_resp,
    input  logic [LINE_WIDTH-1:0]        pmem_rdata,
    output logic [NUM_CH-1:0]            proto_err
);

    localparam int   IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic MODE_FIXED = (ARB_MODE == ARB_FIXED) ? 1'b1 : 1'b0;

    arb_state_t        state_r;
    arb_state_t        state_nx_s;
    logic [IDX_W-1:0]  grant_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  ptr_nx_s;
    logic [IDX_W-1:0]  win_s;
    logic [NUM_CH-1:0] valid_s;
    logic [NUM_CH-1:0] both_s;
    logic              any_valid_s;
    logic              load_s;
    logic              done_s;

    logic [ADDR_WIDTH-1:0] addr_a_s  [NUM_CH];
    logic [LINE_WIDTH-1:0] wdata_a_s [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign addr_a_s[g]  = ch_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a_s[g] = ch_wdata[g*LINE_WIDTH +: LINE_WIDTH];
    end

    // A channel asserting both strobes is flagged and excluded from arbitration.
    assign valid_s  = ch_read ^ ch_write;
    assign both_s   = ch_read & ch_write;
    assign ch_rdata = pmem_rdata;
    assign ptr_nx_s = (grant_r == IDX_W'(NUM_CH - 1)) ? '0 : grant_r + IDX_W'(1);

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .valid     (valid_s),
        .ptr       (ptr_r),
        .mode      (MODE_FIXED),
        .winner    (win_s),
        .any_valid (any_valid_s)
    );

    // Next-state and load/complete decisions.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    state_nx_s = BUSY;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                if (pmem_resp) begin
                    state_nx_s = IDLE;
                    done_s     = 1'b1;
                end else begin
                    state_nx_s = BUSY;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Completion pulse to the granted channel, gated so a stray pmem_resp in IDLE is ignored.
    always_comb begin
        ch_resp = '0;
        if ((state_r == BUSY) && pmem_resp) begin
            ch_resp[grant_r] = 1'b1;
        end else begin
            ch_resp = '0;
        end
    end

    // FSM state, transaction latches, rotating pointer and sticky protocol errors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            ptr_r        <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            proto_err    <= '0;
        end else begin
            state_r   <= state_nx_s;
            proto_err <= proto_err | both_s;
            if (load_s) begin
                grant_r      <= win_s;
                pmem_read    <= ch_read[win_s];
                pmem_write   <= ch_write[win_s];
                pmem_address <= addr_a_s[win_s];
                pmem_wdata   <= wdata_a_s[win_s];
            end else if (done_s) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
                if (ARB_MODE == ARB_RR) begin
                    ptr_r <= ptr_nx_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority 4-channel arbiter with behavioural memories.
module tb_pmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 256;

    typedef struct {
        int            ch;
        logic          wr;
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    rd, wr, resp, perr;
    logic [N*AW-1:0] addr;
    logic [N*LW-1:0] wdata;
    logic [LW-1:0]   rdata, p_wdata, p_rdata;
    logic            p_rd, p_wr, p_resp;
    logic [AW-1:0]   p_addr;

    logic [N-1:0]    f_rd, f_wr, f_resp_v, f_perr;
    logic [N*AW-1:0] f_addr;
    logic [N*LW-1:0] f_wdata;
    logic [LW-1:0]   f_rdata_o, f_pwdata, f_prdata;
    logic            f_prd, f_pwr, f_presp;
    logic [AW-1:0]   f_paddr;

    exp_t q_rr[$];
    exp_t q_fx[$];
    int   errors, checks;
    int   lat_rr, n_rr, n_fx, stop_rr, stop_fx;
    logic force_rr;
    logic [N-1:0] hold_rr, hold_fx;
    logic [LW-1:0] line_fx;

    pmem_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .ch_read(rd), .ch_write(wr), .ch_address(addr),
        .ch_wdata(wdata), .ch_resp(resp), .ch_rdata(rdata), .pmem_read(p_rd),
        .pmem_write(p_wr), .pmem_address(p_addr), .pmem_wdata(p_wdata),
        .pmem_resp(p_resp), .pmem_rdata(p_rdata), .proto_err(perr)
    );

    pmem_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ARB_MODE(1)) u_fx (
        .clk(clk), .rst_n(rst_n), .ch_read(f_rd), .ch_write(f_wr), .ch_address(f_addr),
        .ch_wdata(f_wdata), .ch_resp(f_resp_v), .ch_rdata(f_rdata_o), .pmem_read(f_prd),
        .pmem_write(f_pwr), .pmem_address(f_paddr), .pmem_wdata(f_pwdata),
        .pmem_resp(f_presp), .pmem_rdata(f_prdata), .proto_err(f_perr)
    );

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_item(input string pfx, input exp_t e, input logic [N-1:0] r,
                            input logic prd, input logic pwr, input logic presp,
                            input logic [AW-1:0] pa, input logic [LW-1:0] pwd,
                            input logic [LW-1:0] rdo);
        logic [N-1:0] oh;
        oh = N'(1) << e.ch;
        chk({pfx, "_resp"}, LW'(r), LW'(oh));
        chk({pfx, "_pmem_resp"}, LW'(presp), LW'(1'b1));
        chk({pfx, "_op"}, LW'({prd, pwr}), LW'({~e.wr, e.wr}));
        chk({pfx, "_addr"}, LW'(pa), LW'(e.a));
        if (e.wr) chk({pfx, "_wdata"}, pwd, e.d);
        else      chk({pfx, "_rdata"}, rdo, e.d);
    endtask

    task automatic mon_rr();
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp !== '0) begin
                if (q_rr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rr_unexpected_resp got=%b want=none", resp);
                end else begin
                    e = q_rr.pop_front();
                    chk_item("rr", e, resp, p_rd, p_wr, p_resp, p_addr, p_wdata, rdata);
                end
            end
        end
    endtask

    task automatic mon_fx();
        exp_t e;
        forever begin
            @(negedge clk);
            if (f_resp_v !== '0) begin
                if (q_fx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fx_unexpected_resp got=%b want=none", f_resp_v);
                end else begin
                    e = q_fx.pop_front();
                    chk_item("fx", e, f_resp_v, f_prd, f_pwr, f_presp, f_paddr, f_pwdata, f_rdata_o);
                end
            end
        end
    endtask

    task automatic responder();
        int c_rr, c_fx;
        c_rr = 0;
        c_fx = 0;
        forever begin
            @(posedge clk); #1;
            p_resp  = 1'b0;
            f_presp = 1'b0;
            if (force_rr) begin
                p_resp   = 1'b1;
                force_rr = 1'b0;
            end else if (p_rd || p_wr) begin
                c_rr++;
                if (c_rr >= lat_rr) begin p_resp = 1'b1; c_rr = 0; end
            end else begin
                c_rr = 0;
            end
            if (f_prd || f_pwr) begin
                c_fx++;
                if (c_fx >= 2) begin f_presp = 1'b1; c_fx = 0; end
            end else begin
                c_fx = 0;
            end
        end
    endtask

    // One clock: note completions at the falling edge, then let requesters drop served requests.
    task automatic step();
        logic [N-1:0] s, fs;
        @(negedge clk);
        s  = resp;
        fs = f_resp_v;
        @(posedge clk); #1;
        n_rr += $countones(s);
        n_fx += $countones(fs);
        rd   &= ~(s & ~hold_rr);
        wr   &= ~(s & ~hold_rr);
        f_rd &= ~(fs & ~hold_fx);
        if (stop_rr > 0 && n_rr >= stop_rr) begin rd = '0; wr = '0; end
        if (stop_fx > 0 && n_fx >= stop_fx) f_rd = '0;
    endtask

    task automatic wait_n(input int want_rr, input int want_fx, input int budget, input string nm);
        int k;
        k = 0;
        while ((n_rr < want_rr || n_fx < want_fx) && k < budget) begin
            step();
            k++;
        end
        if (n_rr < want_rr || n_fx < want_fx) begin
            checks++; errors++;
            $display("FAIL timeout_%s got rr=%0d fx=%0d want rr=%0d fx=%0d",
                     nm, n_rr, n_fx, want_rr, want_fx);
        end
    endtask

    task automatic push_rr(input int ch, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
        exp_t e;
        e.ch = ch; e.wr = w; e.a = a; e.d = d;
        q_rr.push_back(e);
    endtask

    task automatic set_a(input int ch, input logic [AW-1:0] a);
        addr[ch*AW +: AW] = a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd = '0; wr = '0; f_rd = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t fe;
        errors = 0; checks = 0;
        lat_rr = 1; n_rr = 0; n_fx = 0; stop_rr = 0; stop_fx = 0;
        force_rr = 1'b0; hold_rr = '0; hold_fx = '0;
        rst_n = 1'b0; rd = '0; wr = '0; addr = '0; wdata = '0;
        f_rd = '0; f_wr = '0; f_addr = '0; f_wdata = '0;
        line_fx = {8{32'hF00D_F00D}};
        f_prdata = line_fx;
        p_rdata = '0; p_resp = 1'b0; f_presp = 1'b0;
        fork
            mon_rr();
            mon_fx();
            responder();
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pmem_read", LW'(p_rd), LW'(1'b0));
        chk("rst_pmem_write", LW'(p_wr), LW'(1'b0));
        chk("rst_ch_resp", LW'(resp), LW'(4'b0000));
        chk("rst_proto_err", LW'(perr), LW'(4'b0000));
        chk("rst_pmem_address", LW'(p_addr), LW'(32'h0));
        chk("rst_pmem_wdata", p_wdata, LW'(1'b0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read on ch1, memory answers after 5 cycles.
        lat_rr = 5; n_rr = 0;
        p_rdata = {32{8'hA5}};
        set_a(1, 32'h0000_0060);
        rd[1] = 1'b1;
        push_rr(1, 1'b0, 32'h0000_0060, {32{8'hA5}});
        step();
        chk("t1_read_latency", LW'(p_rd), LW'(1'b1));
        wait_n(1, 0, 40, "t1");
        repeat (3) step();

        // Simultaneous ch0 read and ch1 write.
        lat_rr = 3; n_rr = 0;
        p_rdata = {8{32'h1234_5678}};
        set_a(0, 32'h0000_0100);
        set_a(1, 32'h0000_0200);
        wdata[1*LW +: LW] = {8{32'hDEAD_BEEF}};
        rd[0] = 1'b1;
        wr[1] = 1'b1;
        push_rr(0, 1'b0, 32'h0000_0100, {8{32'h1234_5678}});
        push_rr(1, 1'b1, 32'h0000_0200, {8{32'hDEAD_BEEF}});
        wait_n(1, 0, 40, "t2a");
        chk("t2_idle_gap", LW'({p_rd, p_wr}), LW'(2'b00));
        step();
        chk("t2_second_is_write", LW'({p_rd, p_wr}), LW'(2'b01));
        wait_n(2, 0, 40, "t2b");
        repeat (3) step();

        // ch2 breaks protocol, ch3 reads normally.
        lat_rr = 2; n_rr = 0;
        rd[2] = 1'b1; wr[2] = 1'b1;
        set_a(3, 32'h0000_0340);
        rd[3] = 1'b1;
        push_rr(3, 1'b0, 32'h0000_0340, {8{32'h1234_5678}});
        step();
        chk("t4_proto_err_set", LW'(perr), LW'(4'b0100));
        wait_n(1, 0, 40, "t4");
        repeat (3) step();
        rd[2] = 1'b0; wr[2] = 1'b0;
        repeat (2) step();
        chk("t4_proto_err_sticky", LW'(perr), LW'(4'b0100));

        // ch1 changes its address while the transaction is in flight.
        lat_rr = 6; n_rr = 0;
        set_a(1, 32'h0000_0300);
        rd[1] = 1'b1;
        push_rr(1, 1'b0, 32'h0000_0300, {8{32'h1234_5678}});
        repeat (2) step();
        set_a(1, 32'h0000_0999);
        step();
        chk("t6_addr_held", LW'(p_addr), LW'(32'h0000_0300));
        wait_n(1, 0, 40, "t6");
        repeat (2) step();

        // Reset while BUSY abandons the transaction and ignores a late response.
        lat_rr = 20; n_rr = 0;
        set_a(1, 32'h0000_0480);
        rd[1] = 1'b1;
        step();
        chk("t5_busy_before_reset", LW'(p_rd), LW'(1'b1));
        step();
        do_reset();
        chk("t5_strobes_drop", LW'({p_rd, p_wr}), LW'(2'b00));
        chk("t5_perr_cleared", LW'(perr), LW'(4'b0000));
        @(negedge clk);
        force_rr = 1'b1;
        @(negedge clk);
        chk("t5_late_resp_present", LW'(p_resp), LW'(1'b1));
        chk("t5_late_resp_ignored", LW'(resp), LW'(4'b0000));
        @(posedge clk); #1;
        repeat (2) step();
        chk("t5_still_idle", LW'({p_rd, p_wr}), LW'(2'b00));
        lat_rr = 2; n_rr = 0;
        set_a(0, 32'h0000_0500); set_a(1, 32'h0000_0540); set_a(2, 32'h0000_0580);
        rd[2:0] = 3'b111;
        push_rr(0, 1'b0, 32'h0000_0500, {8{32'h1234_5678}});
        push_rr(1, 1'b0, 32'h0000_0540, {8{32'h1234_5678}});
        push_rr(2, 1'b0, 32'h0000_0580, {8{32'h1234_5678}});
        wait_n(3, 0, 60, "t5_ptr");
        repeat (2) step();

        // All channels requesting continuously on both arbiters.
        do_reset();
        lat_rr = 1; n_rr = 0; n_fx = 0;
        hold_rr = 4'hF; hold_fx = 4'hF;
        stop_rr = 8; stop_fx = 4;
        for (int i = 0; i < N; i++) set_a(i, 32'h0000_1000 + 32'(i * 64));
        f_addr[0 +: AW] = 32'h0000_2000;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push_rr(i, 1'b0, 32'h0000_1000 + 32'(i * 64), {8{32'h1234_5678}});
        end
        for (int r = 0; r < 4; r++) begin
            fe.ch = 0; fe.wr = 1'b0; fe.a = 32'h0000_2000; fe.d = line_fx;
            q_fx.push_back(fe);
        end
        rd = 4'hF;
        f_rd = 4'hF;
        wait_n(8, 4, 200, "fair");
        stop_rr = 0; stop_fx = 0; hold_rr = '0; hold_fx = '0;
        repeat (6) step();
        chk("rr_queue_drained", LW'(q_rr.size()), LW'(0));
        chk("fx_queue_drained", LW'(q_fx.size()), LW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
